// File: rtl/if_fetch_pkg.sv
// Shared CPU definitions for the instruction fetch stage: FSM states,
// default bubble instruction and the sequential PC increment.
package if_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: kill beats stall, stall beats load, and an
// idle cycle inserts a bubble while keeping the last pc_plus4.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        kill,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc_plus4,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst     <= NOP_INST;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
    end else if (kill) begin
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        inst     <= load_inst;
        pc_plus4 <= load_pc_plus4;
        valid    <= 1'b1;
      end else begin
        inst  <= NOP_INST;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding request to instruction memory,
// a hold register for words returned under a decode stall, and flush draining.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        fetch_busy_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  fetch_state_e state_reg;
  logic         req_reg;
  logic [31:0]  addr_reg;
  logic [31:0]  hold_reg;

  logic         load;
  logic [31:0]  load_inst;
  logic         kill;

  assign imem_req_o  = req_reg;
  assign imem_addr_o = addr_reg;
  assign kill        = flush_i || !start_i;

  // Busy must react in the same cycle so the PC advances exactly once per
  // delivered instruction and can take a branch target on a flush.
  always_comb begin
    fetch_busy_o = 1'b0;
    load         = 1'b0;
    load_inst    = hold_reg;
    case (state_reg)
      ST_ISSUE: fetch_busy_o = start_i && !flush_i;
      ST_WAIT: begin
        if (start_i && !flush_i) begin
          if (!imem_ack_i || stall_i) begin
            fetch_busy_o = 1'b1;
          end else begin
            load      = 1'b1;
            load_inst = imem_data_i;
          end
        end
      end
      ST_HOLD: begin
        if (start_i && !flush_i) begin
          if (stall_i) fetch_busy_o = 1'b1;
          else         load         = 1'b1;
        end
      end
      ST_DRAIN: fetch_busy_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      req_reg   <= 1'b0;
      addr_reg  <= 32'h0;
      hold_reg  <= 32'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          req_reg <= 1'b0;
          if (start_i) state_reg <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!start_i) begin
            state_reg <= ST_IDLE;
          end else if (!flush_i) begin
            addr_reg  <= pc_i;
            req_reg   <= 1'b1;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!start_i || flush_i) begin
            // An in-flight request must complete before a new one is issued.
            if (imem_ack_i) begin
              req_reg   <= 1'b0;
              state_reg <= start_i ? ST_ISSUE : ST_IDLE;
            end else begin
              state_reg <= ST_DRAIN;
            end
          end else if (imem_ack_i) begin
            req_reg <= 1'b0;
            if (stall_i) begin
              hold_reg  <= imem_data_i;
              state_reg <= ST_HOLD;
            end else begin
              state_reg <= ST_ISSUE;
            end
          end
        end
        ST_HOLD: begin
          if (!start_i)                state_reg <= ST_IDLE;
          else if (flush_i || !stall_i) state_reg <= ST_ISSUE;
        end
        ST_DRAIN: begin
          if (imem_ack_i) begin
            req_reg   <= 1'b0;
            state_reg <= start_i ? ST_ISSUE : ST_IDLE;
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .kill         (kill),
    .stall        (stall_i),
    .load         (load),
    .load_inst    (load_inst),
    .load_pc_plus4(addr_reg + PC_INCR),
    .inst         (inst_o),
    .pc_plus4     (pc_plus4_o),
    .valid        (valid_o)
  );

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0000, SHALL be the instruction word driven on inst_o for bubbles and after reset/flush.
REQ-002 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 start_i  in  1  CPU run enable, the same signal that drives the PC register.
REQ-005 pc_i  in  32  current PC from the PC register output.
REQ-006 stall_i  in  1  ID-stage hazard stall; holds the IF/ID outputs.
REQ-007 flush_i  in  1  branch/jump taken; kills the in-flight fetch and the IF/ID contents.
REQ-008 imem_req_o  out  1  instruction memory request, registered.
REQ-009 imem_addr_o  out  32  fetch address, registered.
REQ-010 imem_ack_i  in  1  memory data valid, one-cycle pulse, earliest the cycle after imem_req_o rises.
REQ-011 imem_data_i  in  32  instruction word, valid only with imem_ack_i.
REQ-012 fetch_busy_o  out  1  PC hold request, ORed externally into the PC stall.
REQ-013 inst_o / pc_plus4_o / valid_o  out  32/32/1  IF/ID register contents.

Function
REQ-014 Five states SHALL exist: IDLE, ISSUE, WAIT, HOLD, DRAIN.
REQ-015 IDLE: fetch_busy_o=0; start_i=1 -> ISSUE.
REQ-016 ISSUE, no flush_i: addr_q<=pc_i; -> WAIT; fetch_busy_o=1.
REQ-017 ISSUE, flush_i=1: nothing latched; stay in ISSUE; fetch_busy_o=0 so the PC loads its target.
REQ-018 WAIT/DRAIN: imem_req_o=1 and imem_addr_o=addr_q, both stable until imem_ack_i; imem_req_o=0 in all other states.
REQ-019 WAIT transitions, in priority order:
- flush_i with ack -> data discarded; -> ISSUE; busy=0.
- flush_i without ack -> DRAIN; busy=0.
- ack with stall_i=0 -> IF/ID loaded; -> ISSUE; busy=0.
- ack with stall_i=1 -> data into hold register; -> HOLD; busy=1.
- no ack -> stay in WAIT; busy=1.
REQ-020 HOLD transitions:
- flush_i -> hold data discarded; -> ISSUE; busy=0.
- stall_i=0 -> IF/ID loaded from hold register; -> ISSUE; busy=0.
- otherwise -> stay in HOLD; busy=1.
REQ-021 DRAIN: busy=1; ack -> data discarded; -> ISSUE, which then latches the redirected pc_i.
REQ-022 IF/ID load SHALL set inst_o=data, pc_plus4_o=addr_q+4 (32-bit modulo, so 32'hFFFF_FFFC gives 0), and valid_o=1.
REQ-023 IF/ID update priority:
- flush_i -> valid_o=0, inst_o=NOP_INST.
- else stall_i -> all outputs hold.
- else load per REQ-019/020.
- else bubble: valid_o=0, inst_o=NOP_INST, pc_plus4_o held.
REQ-024 start_i=0 SHALL force IDLE from ISSUE/HOLD and from DRAIN-on-ack; in WAIT it SHALL force DRAIN; IF/ID SHALL be bubbled.
REQ-025 imem_ack_i outside WAIT/DRAIN SHALL be ignored.
REQ-026 Steady-state throughput with 1-cycle memory SHALL be one instruction per 3 cycles (ISSUE, WAIT, ack).

Reset
REQ-027 rst_i=1 at a clock edge SHALL force the following, overriding every other input:
- state=IDLE.
- imem_req_o=0, imem_addr_o=0.
- fetch_busy_o=0.
- inst_o=NOP_INST, pc_plus4_o=0, valid_o=0.
- hold register cleared.
REQ-028 Reset during WAIT/DRAIN SHALL abandon the request; a later stray ack SHALL be ignored per REQ-025.

Structure
REQ-029 The shared CPU package SHALL hold the state enum, NOP_INST default and the PC increment constant 4.
REQ-030 The IF/ID register (REQ-022/023) SHALL be the sub-module if_id_reg; FSM, address and hold registers stay in if_fetch.

Verification
REQ-031 Reset, start_i=1, pc_i=0x0, ack 1 cycle after request with 0x8C010004 -> imem_addr_o=0x0, then inst_o=0x8C010004, pc_plus4_o=0x4, valid_o=1 on the cycle after ack.
REQ-032 Ack arrives 3 cycles late -> imem_req_o and imem_addr_o stay stable 3 cycles, fetch_busy_o=1 throughout, exactly one IF/ID load.
REQ-033 stall_i=1 on ack cycle, held 2 cycles -> HOLD entered, outputs unchanged, then loaded with the held word; the PC does not advance meanwhile.
REQ-034 flush_i in WAIT, pc_i redirected to 0x40, ack with 0xDEADBEEF -> word discarded, valid_o=0, next request address 0x40.
REQ-035 flush_i and stall_i together in HOLD -> valid_o=0, inst_o=NOP_INST; flush wins.
REQ-036 pc_i=0xFFFFFFFC fetched -> pc_plus4_o=0x0; rst_i pulsed in DRAIN -> all outputs at reset values, later ack ignored.
